// File: rtl/exe_pkg.sv
// ============================================================================
// Module      : exe_pkg
// Description : Shared execute-stage types and constants for the iterative
//               divider: FSM state encoding, operation select codes and the
//               default tag width (rd 5 + pc 32 + inst 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic DIV_OP_QUO = 1'b0;
    localparam logic DIV_OP_REM = 1'b1;

    localparam int DIV_TAG_W_DEFAULT = 69;

endpackage

`default_nettype wire

// File: rtl/exe_div_bitlen.sv
// ============================================================================
// Module      : exe_div_bitlen
// Description : Combinational bit length: position of the leading one plus
//               one, or 0 for a zero input.
// Ports       : val_i  [WIDTH-1:0]  operand
//               len_o  [LEN_W-1:0]  bit length of val_i (0..WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_div_bitlen #(
    parameter int WIDTH = 32,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [LEN_W-1:0] len_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        len_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (val_i[i]) begin
                len_o = LEN_W'(i + 1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/exe_div_iter.sv
// ============================================================================
// Module      : exe_div_iter
// Description : Iterative radix-2 restoring integer divider with valid/ready
//               handshakes on both sides, signed/unsigned operands, defined
//               divide-by-zero result and an opaque pass-through tag.
//               One quotient bit is produced per CALC cycle.
// Config      : DIV_EARLY_OUT_EN - when defined, operands are normalised by
//               bit length so only the needed quotient bits are iterated and
//               zero-divisor / |a|<|b| requests finish straight from PREP.
//               When undefined every request takes WIDTH CALC cycles; the
//               results are identical, only the latency differs.
// Ports       : clk, rst (sync, active-high), flush (aborts in-flight op)
//               in_valid/in_ready, in_op (0 quo, 1 rem), in_sign, in_a, in_b,
//               in_tag                              - request side
//               out_valid/out_ready, out_result, out_tag - result side
//               busy                                - high in PREP/CALC/DONE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_div_iter
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = DIV_TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int LW = $clog2(WIDTH + 1);
    // The divisor register is double width so the non-normalised build can
    // pre-align the divisor by WIDTH-1 bits.
    localparam int DW = 2 * WIDTH;

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] abs_a_q, abs_a_d, abs_b_q, abs_b_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [DW-1:0]    div_q, div_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d, busy_q, busy_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             w_div_zero, w_prep_short, w_rem_ge;
    logic [DW-1:0]    w_prep_div;
    logic [LW-1:0]    w_prep_cnt;
    logic [WIDTH-1:0] w_rem_sub;

    assign w_div_zero = (abs_b_q == '0);

`ifdef DIV_EARLY_OUT_EN
    logic [LW-1:0] w_len_a, w_len_b, w_shift;

    exe_div_bitlen #(.WIDTH(WIDTH), .LEN_W(LW)) u_len_a (.val_i(abs_a_q), .len_o(w_len_a));
    exe_div_bitlen #(.WIDTH(WIDTH), .LEN_W(LW)) u_len_b (.val_i(abs_b_q), .len_o(w_len_b));

    // Shortcut taken only when |a|<|b| or b==0, so w_len_a >= w_len_b below.
    assign w_shift      = w_len_a - w_len_b;
    assign w_prep_short = w_div_zero | (abs_a_q < abs_b_q);
    assign w_prep_div   = {{WIDTH{1'b0}}, abs_b_q} << w_shift;
    assign w_prep_cnt   = w_shift + LW'(1);
`else
    assign w_prep_short = 1'b0;
    assign w_prep_div   = {{WIDTH{1'b0}}, abs_b_q} << (WIDTH - 1);
    assign w_prep_cnt   = LW'(WIDTH);
`endif

    // Whenever rem >= div, div fits in WIDTH bits, so the narrow subtract is exact.
    assign w_rem_ge  = ({{WIDTH{1'b0}}, rem_q} >= div_q);
    assign w_rem_sub = rem_q - div_q[WIDTH-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = PREP;
            PREP:    state_d = w_prep_short ? DONE : CALC;
            CALC:    if (cnt_q == LW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output next-values
    // ------------------------------------------------------------------
    logic             fin;
    logic [WIDTH-1:0] fin_quo, fin_rem, fix_quo, fix_rem;

    always_comb begin
        abs_a_d      = abs_a_q;
        abs_b_d      = abs_b_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        op_d         = op_q;
        tag_d        = tag_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        fin          = 1'b0;
        fin_quo      = quo_q;
        fin_rem      = rem_q;
        fix_quo      = '0;
        fix_rem      = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_a_d = in_sign & in_a[WIDTH-1];
                    sign_b_d = in_sign & in_b[WIDTH-1];
                    abs_a_d  = (in_sign & in_a[WIDTH-1]) ? -in_a : in_a;
                    abs_b_d  = (in_sign & in_b[WIDTH-1]) ? -in_b : in_b;
                    op_d     = in_op;
                    tag_d    = in_tag;
                    busy_d   = 1'b1;
                end
            end
            PREP: begin
                rem_d = abs_a_q;
                quo_d = '0;
                div_d = w_prep_div;
                cnt_d = w_prep_cnt;
                if (w_prep_short) begin
                    fin     = 1'b1;
                    fin_quo = '0;
                    fin_rem = abs_a_q;
                end
            end
            CALC: begin
                div_d = div_q >> 1;
                cnt_d = cnt_q - LW'(1);
                if (w_rem_ge) begin
                    rem_d = w_rem_sub;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == LW'(1)) begin
                    fin     = 1'b1;
                    fin_quo = quo_d;
                    fin_rem = rem_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase

        // Sign fix on DONE entry. MIN / -1 needs no special case: the
        // WIDTH-bit negation of magnitude 2^(WIDTH-1) wraps back to MIN.
        if (fin) begin
            fix_quo      = w_div_zero ? '1 : ((sign_a_q ^ sign_b_q) ? -fin_quo : fin_quo);
            fix_rem      = sign_a_q ? -fin_rem : fin_rem;
            out_valid_d  = 1'b1;
            out_result_d = (op_q == DIV_OP_REM) ? fix_rem : fix_quo;
            out_tag_d    = tag_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            abs_a_q      <= '0;
            abs_b_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            op_q         <= 1'b0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            abs_a_q      <= abs_a_d;
            abs_b_q      <= abs_b_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_div_iter.sv
// ============================================================================
// Module      : tb_exe_div_iter
// Description : Self-checking bench for exe_div_iter. A 32-bit instance and a
//               16-bit instance are exercised against a plain-arithmetic
//               reference model (64-bit signed division) and a latency model
//               derived from operand magnitudes. Honours DIV_EARLY_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_div_iter;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic        v32, rdy32, op32, sg32, ov32, ordy32, busy32;
    logic [31:0] a32, b32, res32;
    logic [68:0] tag32, otag32;

    logic        v16, rdy16, op16, sg16, ov16, ordy16, busy16;
    logic [15:0] a16, b16, res16;
    logic [7:0]  tag16, otag16;

    int n_tests = 0;
    int n_fail  = 0;

    exe_div_iter #(.WIDTH(32), .TAG_W(69)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v32), .in_ready(rdy32), .in_op(op32), .in_sign(sg32),
        .in_a(a32), .in_b(b32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(ordy32), .out_result(res32), .out_tag(otag32),
        .busy(busy32)
    );

    exe_div_iter #(.WIDTH(16), .TAG_W(8)) dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v16), .in_ready(rdy16), .in_op(op16), .in_sign(sg16),
        .in_a(a16), .in_b(b16), .in_tag(tag16),
        .out_valid(ov16), .out_ready(ordy16), .out_result(res16), .out_tag(otag16),
        .busy(busy16)
    );

    // ---------------- reference models ----------------
    function automatic logic [63:0] model(input int w, input logic op, input logic sg,
                                          input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, q, r;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a & mask);
        sb = longint'(b & mask);
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return (op ? r : q) & mask;
    endfunction

    function automatic int blen(input longint unsigned x);
        int l = 0;
        while (x != 0) begin
            l++;
            x = x >> 1;
        end
        return l;
    endfunction

    function automatic int exp_lat(input int w, input logic sg,
                                   input logic [63:0] a, input logic [63:0] b);
        longint unsigned ma, mb, full;
        if (!EO) return w + 2;
        full = longint'(1) << w;
        ma = a & (full - 1);
        mb = b & (full - 1);
        if (sg && a[w-1]) ma = full - ma;
        if (sg && b[w-1]) mb = full - mb;
        if (mb == 0 || ma < mb) return 2;
        return 2 + blen(ma) - blen(mb) + 1;
    endfunction

    // ---------------- transaction drivers (no checking) ----------------
    // lat counts the cycle after acceptance as 1; -1 means no result appeared.
    task automatic do32(input logic op, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [68:0] tg,
                        output logic [31:0] res, output logic [68:0] otg, output int lat);
        int guard = 0;
        lat = -1;
        op32 = op; sg32 = sg; a32 = a; b32 = b; tag32 = tg; v32 = 1'b1;
        while (!rdy32 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        for (int n = 1; n < 200; n++) begin
            if (ov32) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        res = res32;
        otg = otag32;
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
    endtask

    task automatic do16(input logic op, input logic sg, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] tg,
                        output logic [15:0] res, output logic [7:0] otg, output int lat);
        int guard = 0;
        lat = -1;
        op16 = op; sg16 = sg; a16 = a; b16 = b; tag16 = tg; v16 = 1'b1;
        while (!rdy16 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        v16 = 1'b0;
        for (int n = 1; n < 200; n++) begin
            if (ov16) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        res = res16;
        otg = otag16;
        ordy16 = 1'b1;
        @(posedge clk); #1;
        ordy16 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        v32 = 1'b1; op32 = 1'b0; sg32 = 1'b0; a32 = 32'd9; b32 = 32'd3; tag32 = '1; ordy32 = 1'b0;
        v16 = 1'b1; op16 = 1'b0; sg16 = 1'b0; a16 = 16'd9; b16 = 16'd3; tag16 = '1; ordy16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; v32 = 1'b0; v16 = 1'b0;
        n_tests++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid32 got %0b want 0", ov32); end
        n_tests++; if (res32 !== 32'd0) begin n_fail++; $display("FAIL reset_result32 got %h want 0", res32); end
        n_tests++; if (otag32 !== 69'd0) begin n_fail++; $display("FAIL reset_tag32 got %h want 0", otag32); end
        n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy32 got %0b want 0", busy32); end
        n_tests++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready32 got %0b want 1", rdy32); end
        n_tests++; if ({ov16, busy16, rdy16, res16, otag16} !== {1'b0, 1'b0, 1'b1, 16'd0, 8'd0})
            begin n_fail++; $display("FAIL reset_state16 got v=%0b b=%0b r=%0b res=%h tag=%h want 0 0 1 0 0",
                                    ov16, busy16, rdy16, res16, otag16); end
    endtask

    typedef struct {
        logic        op;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat_eo;
    } dvec_t;

    task automatic test_directed();
        dvec_t tbl[12];
        logic [31:0] res;
        logic [68:0] tg, otg;
        int lat, elat;
        tbl[0]  = '{1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        7};
        tbl[1]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         7};
        tbl[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  4};
        tbl[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  4};
        tbl[4]  = '{1'b0, 1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  4};
        tbl[5]  = '{1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  32'd1,         4};
        tbl[6]  = '{1'b0, 1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  2};
        tbl[7]  = '{1'b1, 1'b0, 32'h1234,      32'd0,         32'h1234,      2};
        tbl[8]  = '{1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  34};
        tbl[9]  = '{1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         34};
        tbl[10] = '{1'b1, 1'b1, 32'hFFFFFFF0,  32'd0,         32'hFFFFFFF0,  2};
        tbl[11] = '{1'b0, 1'b0, 32'd5,         32'd7,         32'd0,         2};
        foreach (tbl[i]) begin
            tg = {$urandom, $urandom, 5'($urandom)};
            do32(tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b, tg, res, otg, lat);
            elat = EO ? tbl[i].lat_eo : 34;
            n_tests++; if (res !== tbl[i].exp) begin n_fail++;
                $display("FAIL directed_result[%0d] got %h want %h", i, res, tbl[i].exp); end
            n_tests++; if (otg !== tg) begin n_fail++;
                $display("FAIL directed_tag[%0d] got %h want %h", i, otg, tg); end
            n_tests++; if (lat !== elat) begin n_fail++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, elat); end
        end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, res;
        logic [68:0] tg, otg;
        logic [63:0] e;
        logic op, sg;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom); sg = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 300);
                2: b = $urandom >> $urandom_range(0, 31);
                3: b = 32'd0;
                default: b = 32'hFFFFFFFF;
            endcase
            tg = {$urandom, $urandom, 5'($urandom)};
            e = model(32, op, sg, {32'd0, a}, {32'd0, b});
            elat = exp_lat(32, sg, {32'd0, a}, {32'd0, b});
            do32(op, sg, a, b, tg, res, otg, lat);
            n_tests++; if (res !== e[31:0] || otg !== tg || lat !== elat) begin n_fail++;
                $display("FAIL random32[%0d] op=%0b sg=%0b a=%h b=%h got res=%h tag_ok=%0b lat=%0d want res=%h lat=%0d",
                         i, op, sg, a, b, res, otg === tg, lat, e[31:0], elat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r0, res;
        logic [68:0] tg, t0, otg;
        logic [63:0] e;
        int guard = 0, lat, bad = 0;
        tg = {$urandom, $urandom, 5'($urandom)};
        op32 = 1'b0; sg32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; tag32 = tg; v32 = 1'b1;
        while (!rdy32 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        v32 = 1'b0;
        guard = 0;
        while (!ov32 && guard < 100) begin @(posedge clk); #1; guard++; end
        r0 = res32; t0 = otag32;
        n_tests++; if (ov32 !== 1'b1 || r0 !== 32'd333 || t0 !== tg) begin n_fail++;
            $display("FAIL bp_first_result got v=%0b res=%h want v=1 res=%h", ov32, r0, 32'd333); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if ({ov32, res32, otag32, rdy32, busy32} !== {1'b1, r0, t0, 1'b0, 1'b1}) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
        n_tests++; if (rdy32 !== 1'b1 || ov32 !== 1'b0 || busy32 !== 1'b0) begin n_fail++;
            $display("FAIL bp_release got rdy=%0b v=%0b busy=%0b want 1 0 0", rdy32, ov32, busy32); end
        e = model(32, 1'b1, 1'b1, 64'hFFFFFC19, 64'd10);
        do32(1'b1, 1'b1, 32'hFFFFFC19, 32'd10, tg, res, otg, lat);
        n_tests++; if (res !== e[31:0] || otg !== tg) begin n_fail++;
            $display("FAIL bp_next_request got %h want %h", res, e[31:0]); end
    endtask

    task automatic test_flush32();
        logic [31:0] res;
        logic [68:0] otg;
        logic [63:0] e;
        int guard = 0, lat, bad = 0;
        op32 = 1'b0; sg32 = 1'b0; a32 = 32'd100; b32 = 32'd7; tag32 = 69'h5; v32 = 1'b1;
        while (!rdy32 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;            // E0 + 1
        v32 = 1'b0;
        @(posedge clk); #1;            // E0 + 2: flush and a competing request land on E0+3
        flush = 1'b1; v32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; v32 = 1'b0;
        n_tests++; if (ov32 !== 1'b0 || rdy32 !== 1'b1 || busy32 !== 1'b0) begin n_fail++;
            $display("FAIL flush32_abort got v=%0b rdy=%0b busy=%0b want 0 1 0", ov32, rdy32, busy32); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ov32 !== 1'b0 || busy32 !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++;
            $display("FAIL flush32_ignored_request got %0d active cycles want 0", bad); end
        e = model(32, 1'b0, 1'b1, 64'hFFFF0000, 64'd7);
        do32(1'b0, 1'b1, 32'hFFFF0000, 32'd7, 69'h1AB, res, otg, lat);
        n_tests++; if (res !== e[31:0] || otg !== 69'h1AB || lat !== exp_lat(32, 1'b1, 64'hFFFF0000, 64'd7)) begin n_fail++;
            $display("FAIL flush32_after got res=%h lat=%0d want %h", res, lat, e[31:0]); end
    endtask

    task automatic test_width16();
        logic [15:0] a, b, res;
        logic [7:0] tg, otg;
        logic [63:0] e;
        logic op, sg;
        int lat, elat, guard = 0, bad = 0;
        do16(1'b0, 1'b1, 16'h8000, 16'hFFFF, 8'h3C, res, otg, lat);
        n_tests++; if (res !== 16'h8000 || otg !== 8'h3C || lat !== (EO ? 18 : 18)) begin n_fail++;
            $display("FAIL w16_min_neg1 got %h lat=%0d want 8000 lat=18", res, lat); end
        for (int i = 0; i < 25; i++) begin
            op = 1'($urandom); sg = 1'($urandom);
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom);
                1: b = 16'($urandom_range(1, 40));
                2: b = 16'd0;
                default: b = 16'($urandom) >> $urandom_range(0, 15);
            endcase
            tg = 8'($urandom);
            e = model(16, op, sg, {48'd0, a}, {48'd0, b});
            elat = exp_lat(16, sg, {48'd0, a}, {48'd0, b});
            do16(op, sg, a, b, tg, res, otg, lat);
            n_tests++; if (res !== e[15:0] || otg !== tg || lat !== elat) begin n_fail++;
                $display("FAIL random16[%0d] op=%0b sg=%0b a=%h b=%h got res=%h lat=%0d want res=%h lat=%0d",
                         i, op, sg, a, b, res, lat, e[15:0], elat); end
        end
        // Flush mid-CALC with a competing request in the flush cycle.
        op16 = 1'b0; sg16 = 1'b0; a16 = 16'hFFFF; b16 = 16'd3; tag16 = 8'h11; v16 = 1'b1;
        while (!rdy16 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        v16 = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1; v16 = 1'b1; a16 = 16'd9;
        @(posedge clk); #1;
        flush = 1'b0; v16 = 1'b0;
        n_tests++; if (ov16 !== 1'b0 || rdy16 !== 1'b1 || busy16 !== 1'b0) begin n_fail++;
            $display("FAIL flush16_abort got v=%0b rdy=%0b busy=%0b want 0 1 0", ov16, rdy16, busy16); end
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (ov16 !== 1'b0 || busy16 !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++;
            $display("FAIL flush16_ignored_request got %0d active cycles want 0", bad); end
        do16(1'b1, 1'b0, 16'd1000, 16'd7, 8'h77, res, otg, lat);
        n_tests++; if (res !== 16'd6 || otg !== 8'h77) begin n_fail++;
            $display("FAIL flush16_after got %h want 0006", res); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random32();
        test_backpressure();
        test_flush32();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
